// File: rtl/indirect_protect_trap_ctl_pkg.sv
// Shared widths, trap cause and FSM encoding for the indirect-pointer trap controller.
package indirect_protect_trap_ctl_pkg;

  localparam int XLEN        = 32;
  localparam int PC_BITWIDTH = 32;

  localparam logic [4:0] TRAP_CAUSE_INDIRECT_PTR = 5'd24;

  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_WAIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'(1 << S_IDLE),
    ST_REQ  = 3'(1 << S_REQ),
    ST_WAIT = 3'(1 << S_WAIT)
  } trap_state_e;

endpackage

// File: rtl/indirect_protect_log_fifo.sv
// Violation log: small FIFO with wrap-bit pointers and a sticky overflow flag for dropped pushes.
module indirect_protect_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sync_reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full log still lands.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (sync_reset || clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (push && !push_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr && !sync_reset) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data  = mem[rd_ptr_q[AW-1:0]];
  assign overflow = ovf_q;

endmodule

// File: rtl/indirect_protect_trap_ctl.sv
// Turns each rising edge of the indirect-pointer detector flag into one trap request,
// logging the offending PC/IR and counting violations.
module indirect_protect_trap_ctl
  import indirect_protect_trap_ctl_pkg::*;
#(
  parameter int LOG_DEPTH = 4,
  parameter int CNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   exe_enable,
  input  logic [PC_BITWIDTH-1:0] PC_in,
  input  logic [XLEN-1:0]        IR_in,
  input  logic                   indirect_protect_active,
  input  logic                   protect_enable,
  input  logic                   exception_handler_active,
  output logic                   trap_req,
  input  logic                   trap_ack,
  output logic [4:0]             trap_cause,
  output logic [PC_BITWIDTH-1:0] trap_pc,
  input  logic                   log_rd_en,
  output logic [PC_BITWIDTH-1:0] log_rd_pc,
  output logic [XLEN-1:0]        log_rd_ir,
  output logic                   log_empty,
  output logic                   log_overflow,
  input  logic                   log_clr,
  output logic [CNT_BITS-1:0]    violation_cnt
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic                   act_q, act_d;
  logic [PC_BITWIDTH-1:0] sh_pc_q, sh_pc_d;
  logic [XLEN-1:0]        sh_ir_q, sh_ir_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   ev;

  trap_state_e            state_q;
  logic                   wait_armed_q;
  logic                   trap_req_q;
  logic [4:0]             trap_cause_q;
  logic [PC_BITWIDTH-1:0] trap_pc_q;

  logic [PC_BITWIDTH+XLEN-1:0] log_rd_data;

  assign ev = indirect_protect_active & ~act_q;

  always_comb begin
    act_d   = indirect_protect_active;
    sh_pc_d = exe_enable ? PC_in : sh_pc_q;
    sh_ir_d = exe_enable ? IR_in : sh_ir_q;
    cnt_d   = (ev && (cnt_q != '1)) ? cnt_q + CNT_ONE : cnt_q;
    if (sync_reset) begin
      act_d   = 1'b0;
      sh_pc_d = '0;
      sh_ir_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q   <= 1'b0;
      sh_pc_q <= '0;
      sh_ir_q <= '0;
      cnt_q   <= '0;
    end else begin
      act_q   <= act_d;
      sh_pc_q <= sh_pc_d;
      sh_ir_q <= sh_ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only an event seen in IDLE can raise a trap; later ones are logged and counted only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wait_armed_q <= 1'b0;
      trap_req_q   <= 1'b0;
      trap_cause_q <= '0;
      trap_pc_q    <= '0;
    end else if (sync_reset) begin
      state_q      <= ST_IDLE;
      wait_armed_q <= 1'b0;
      trap_req_q   <= 1'b0;
      trap_cause_q <= '0;
      trap_pc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ev && protect_enable) begin
            state_q      <= ST_REQ;
            trap_req_q   <= 1'b1;
            trap_cause_q <= TRAP_CAUSE_INDIRECT_PTR;
            trap_pc_q    <= sh_pc_q;
          end
        end
        ST_REQ: begin
          if (trap_ack) begin
            state_q      <= ST_WAIT;
            wait_armed_q <= 1'b0;
            trap_req_q   <= 1'b0;
            trap_cause_q <= '0;
          end
        end
        ST_WAIT: begin
          // Skip the first WAIT cycle so the handler has time to raise its active flag.
          if (!wait_armed_q)                  wait_armed_q <= 1'b1;
          else if (!exception_handler_active) state_q      <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          trap_req_q   <= 1'b0;
          trap_cause_q <= '0;
        end
      endcase
    end
  end

  indirect_protect_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (PC_BITWIDTH + XLEN)
  ) u_log (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .clr        (log_clr),
    .push       (ev),
    .pop        (log_rd_en),
    .wr_data    ({sh_pc_q, sh_ir_q}),
    .rd_data    (log_rd_data),
    .empty      (log_empty),
    .overflow   (log_overflow)
  );

  assign log_rd_pc     = log_rd_data[PC_BITWIDTH+XLEN-1:XLEN];
  assign log_rd_ir     = log_rd_data[XLEN-1:0];
  assign trap_req      = trap_req_q;
  assign trap_cause    = trap_cause_q;
  assign trap_pc       = trap_pc_q;
  assign violation_cnt = cnt_q;

endmodule

// File: tb/tb_indirect_protect_trap_ctl.sv
// Bench for indirect_protect_trap_ctl: directed scenarios plus random traffic, all checked
// each cycle against a queue-based behavioural model.
module tb_indirect_protect_trap_ctl;
  import indirect_protect_trap_ctl_pkg::*;

  localparam int DEPTH = 4;
  localparam int CB    = 5;
  localparam int CMAX  = (1 << CB) - 1;

  logic        clk = 1'b0;
  logic        reset_n, sync_reset, exe_enable;
  logic [31:0] PC_in, IR_in;
  logic        indirect_protect_active, protect_enable, exception_handler_active;
  logic        trap_req, trap_ack;
  logic [4:0]  trap_cause;
  logic [31:0] trap_pc;
  logic        log_rd_en;
  logic [31:0] log_rd_pc, log_rd_ir;
  logic        log_empty, log_overflow, log_clr;
  logic [CB-1:0] violation_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  indirect_protect_trap_ctl #(.LOG_DEPTH(DEPTH), .CNT_BITS(CB)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .exe_enable(exe_enable),
    .PC_in(PC_in), .IR_in(IR_in), .indirect_protect_active(indirect_protect_active),
    .protect_enable(protect_enable), .exception_handler_active(exception_handler_active),
    .trap_req(trap_req), .trap_ack(trap_ack), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .log_rd_en(log_rd_en), .log_rd_pc(log_rd_pc), .log_rd_ir(log_rd_ir),
    .log_empty(log_empty), .log_overflow(log_overflow), .log_clr(log_clr),
    .violation_cnt(violation_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the log is a queue, the trap is a phase (0 idle, 1 requesting, 2 handler).
  logic [63:0] m_q[$];
  bit          m_ovf, m_act, m_ev, m_pop_ok;
  int          m_cnt, m_phase, m_wait;
  logic [31:0] m_shpc, m_shir, m_tpc;

  always @(posedge clk) begin
    if (!reset_n || sync_reset) begin
      m_q.delete();
      m_ovf = 0; m_act = 0; m_cnt = 0; m_phase = 0; m_wait = 0;
      m_shpc = '0; m_shir = '0; m_tpc = '0;
    end else begin
      m_ev = indirect_protect_active && !m_act;
      if (log_clr) begin
        m_q.delete();
        m_ovf = 0;
      end else begin
        m_pop_ok = log_rd_en && (m_q.size() > 0);
        if (m_pop_ok) void'(m_q.pop_front());
        if (m_ev) begin
          if (m_q.size() < DEPTH) m_q.push_back({m_shpc, m_shir});
          else m_ovf = 1;
        end
      end
      if (m_ev && m_cnt < CMAX) m_cnt++;
      case (m_phase)
        0: if (m_ev && protect_enable) begin m_phase = 1; m_tpc = m_shpc; end
        1: if (trap_ack) begin m_phase = 2; m_wait = 0; end
        default: if (m_wait >= 1 && !exception_handler_active) m_phase = 0; else m_wait++;
      endcase
      m_act = indirect_protect_active;
      if (exe_enable) begin m_shpc = PC_in; m_shir = IR_in; end
    end
    #1;
    chk("m_trap_req", trap_req, m_phase == 1);
    chk("m_trap_cause", trap_cause, (m_phase == 1) ? 5'd24 : 5'd0);
    if (m_phase == 1) chk("m_trap_pc", trap_pc, m_tpc);
    chk("m_log_empty", log_empty, m_q.size() == 0);
    if (m_q.size() > 0) chk("m_log_head", {log_rd_pc, log_rd_ir}, m_q[0]);
    chk("m_log_overflow", log_overflow, m_ovf);
    chk("m_violation_cnt", violation_cnt, 64'(m_cnt));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_sw(input logic [31:0] pc, input logic [31:0] ir);
    exe_enable = 1'b1; PC_in = pc; IR_in = ir;
    cyc(1);
    exe_enable = 1'b0;
  endtask

  task automatic flag();
    indirect_protect_active = 1'b1; cyc(1);
    indirect_protect_active = 1'b0; cyc(1);
  endtask

  task automatic srst();
    sync_reset = 1'b1; cyc(1); sync_reset = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [31:0] pc, input logic [31:0] ir);
    chk({nm, "_nonempty"}, log_empty, 1'b0);
    chk({nm, "_pc"}, log_rd_pc, pc);
    chk({nm, "_ir"}, log_rd_ir, ir);
    log_rd_en = 1'b1; cyc(1); log_rd_en = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 16 && !log_empty; i++) begin
      log_rd_en = 1'b1; cyc(1); n++;
    end
    log_rd_en = 1'b0;
  endtask

  logic [31:0] pcs [3];
  logic [31:0] irs [3];
  int          n;

  initial begin
    reset_n = 0; sync_reset = 0; exe_enable = 0; PC_in = '0; IR_in = '0;
    indirect_protect_active = 0; protect_enable = 0; exception_handler_active = 0;
    trap_ack = 0; log_rd_en = 0; log_clr = 0;
    cyc(3); reset_n = 1; cyc(1);
    chk("rst_req", trap_req, 1'b0);
    chk("rst_cause", trap_cause, 5'd0);
    chk("rst_pc", trap_pc, 32'h0);
    chk("rst_empty", log_empty, 1'b1);
    chk("rst_ovf", log_overflow, 1'b0);
    chk("rst_cnt", violation_cnt, 5'd0);

    // 1: single trap with handshake
    protect_enable = 1;
    load_sw(32'h80043298, 32'h0000A023);
    indirect_protect_active = 1; cyc(1);
    chk("t1_req", trap_req, 1'b1);
    chk("t1_pc", trap_pc, 32'h80043298);
    chk("t1_cause", trap_cause, 5'd24);
    indirect_protect_active = 0; cyc(3);
    chk("t1_req_held", trap_req, 1'b1);
    trap_ack = 1; cyc(1); trap_ack = 0;
    chk("t1_req_drop", trap_req, 1'b0);
    chk("t1_cnt", violation_cnt, 5'd1);
    pop_chk("t1_log", 32'h80043298, 32'h0000A023);
    chk("t1_empty", log_empty, 1'b1);
    cyc(3);

    // 2: log/count only
    srst(); protect_enable = 0;
    pcs = '{32'h100, 32'h204, 32'h30C};
    irs = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    for (int k = 0; k < 3; k++) begin load_sw(pcs[k], irs[k]); flag(); end
    chk("t2_no_req", trap_req, 1'b0);
    chk("t2_cnt", violation_cnt, 5'd3);
    for (int k = 0; k < 3; k++) pop_chk("t2_log", pcs[k], irs[k]);

    // 3: overflow keeps the first four
    srst();
    for (int k = 0; k < 6; k++) begin
      load_sw(32'h1000 + 32'(k * 4), 32'hC0DE0000 + 32'(k)); flag();
    end
    chk("t3_ovf", log_overflow, 1'b1);
    for (int k = 0; k < 4; k++) pop_chk("t3_log", 32'h1000 + 32'(k * 4), 32'hC0DE0000 + 32'(k));
    chk("t3_empty", log_empty, 1'b1);
    log_clr = 1; cyc(1); log_clr = 0;
    chk("t3_clr_ovf", log_overflow, 1'b0);
    chk("t3_clr_empty", log_empty, 1'b1);

    // 4: second event while requesting; return to IDLE only after handler falls
    srst(); protect_enable = 1;
    load_sw(32'hA000, 32'h1); flag();
    chk("t4_req", trap_req, 1'b1);
    load_sw(32'hB000, 32'h2); flag(); cyc(6);
    chk("t4_pc_stable", trap_pc, 32'hA000);
    chk("t4_cnt", violation_cnt, 5'd2);
    exception_handler_active = 1; trap_ack = 1; cyc(1); trap_ack = 0;
    chk("t4_req_drop", trap_req, 1'b0);
    drain(n);
    chk("t4_entries", 64'(n), 64'd2);
    cyc(3);
    load_sw(32'hC000, 32'h3); flag();
    chk("t4_no_req_in_wait", trap_req, 1'b0);
    exception_handler_active = 0; cyc(3);
    load_sw(32'hD000, 32'h4); flag();
    chk("t4_req_again", trap_req, 1'b1);
    chk("t4_pc_again", trap_pc, 32'hD000);
    trap_ack = 1; cyc(1); trap_ack = 0; cyc(3);

    // 5: counter saturation and push+pop on a full log
    srst(); protect_enable = 0;
    repeat (CMAX + 2) flag();
    chk("t5_cnt_sat", violation_cnt, 5'h1F);
    log_clr = 1; cyc(1); log_clr = 0;
    repeat (4) flag();
    chk("t5_full_no_ovf", log_overflow, 1'b0);
    indirect_protect_active = 1; log_rd_en = 1; cyc(1);
    indirect_protect_active = 0; log_rd_en = 0; cyc(1);
    chk("t5_pushpop_ovf", log_overflow, 1'b0);
    drain(n);
    chk("t5_entries", 64'(n), 64'd4);

    // 6: async reset while requesting, sync reset while waiting
    srst(); protect_enable = 1;
    load_sw(32'hE000, 32'h5); flag();
    chk("t6_req", trap_req, 1'b1);
    reset_n = 0; #1;
    chk("t6_async_req", trap_req, 1'b0);
    cyc(1); reset_n = 1; cyc(1);
    load_sw(32'hF000, 32'h6); flag();
    exception_handler_active = 1; trap_ack = 1; cyc(1); trap_ack = 0; cyc(2);
    srst();
    chk("t6_srst_empty", log_empty, 1'b1);
    chk("t6_srst_cnt", violation_cnt, 5'd0);
    load_sw(32'hF100, 32'h7); flag();
    chk("t6_idle_after_srst", trap_req, 1'b1);
    trap_ack = 1; cyc(1); trap_ack = 0; exception_handler_active = 0; cyc(3);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      exe_enable               = ($urandom_range(0, 1) == 1);
      PC_in                    = $urandom;
      IR_in                    = $urandom;
      indirect_protect_active  = ($urandom_range(0, 9) < 4);
      protect_enable           = ($urandom_range(0, 9) < 7);
      exception_handler_active = ($urandom_range(0, 9) < 5);
      trap_ack                 = ($urandom_range(0, 9) < 2);
      log_rd_en                = ($urandom_range(0, 9) < 2);
      log_clr                  = ($urandom_range(0, 99) < 3);
      sync_reset               = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    exe_enable = 0; indirect_protect_active = 0; trap_ack = 0;
    log_rd_en = 0; log_clr = 0; sync_reset = 0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
